// File: rtl/hist_readout.sv
// ----------------------------------------------------------------------------
// hist_readout
//
// Command-driven readout of the four 32-bit histogram counters. A command
// byte from the UART receiver snapshots all four counters on one edge.
// The snapshot is then streamed, MSB byte first and histo0 first, to the
// UART transmitter over a valid/ready handshake. A command can also request
// a 4-cycle clear pulse on resethist.
//
// Optional feature (macro HIST_CHECKSUM_EN): after the 16 data bytes, a 17th
// byte is sent. It is the XOR of the 16 data bytes.
//
// Ports:
//   clkin, nrst          clock, asynchronous active-low reset
//   histo0..histo3       live 32-bit histogram counters
//   rx_data, rx_valid    command byte + one-cycle strobe
//   tx_data, tx_valid    registered byte stream to UART transmitter
//   tx_ready             transmitter accepts on tx_valid && tx_ready
//   resethist            clear request, high for 4 cycles per CLEAR/READCLR
//   busy                 high while a stream is in progress
//   dropped              saturating count of commands ignored while busy
// ----------------------------------------------------------------------------
module hist_readout (
    input  logic        clkin,
    input  logic        nrst,
    input  logic [31:0] histo0,
    input  logic [31:0] histo1,
    input  logic [31:0] histo2,
    input  logic [31:0] histo3,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        resethist,
    output logic        busy,
    output logic [7:0]  dropped
);

    localparam logic [7:0] CMD_READ    = 8'h01;
    localparam logic [7:0] CMD_CLEAR   = 8'h02;
    localparam logic [7:0] CMD_READCLR = 8'h03;

`ifdef HIST_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, CSUM} state_t;
`else
    typedef enum logic [0:0] {IDLE, SEND} state_t;
`endif

    state_t         state_q, state_d;
    logic [127:0]   snap_q, snap_d;
    logic [3:0]     idx_q, idx_d;
    logic [7:0]     tx_data_q, tx_data_d;
    logic           tx_valid_q, tx_valid_d;
    logic [2:0]     clr_q, clr_d;
    logic [7:0]     dropped_q, dropped_d;

    logic           cmd_go, start_read, start_clr, hs;
    logic [3:0]     idx_nxt;
    logic [7:0]     byte_nxt;

    // Commands are only sampled in IDLE; anything arriving while busy is
    // counted as dropped, whatever its value.
    assign cmd_go     = rx_valid && (state_q == IDLE);
    assign start_read = cmd_go && (rx_data == CMD_READ || rx_data == CMD_READCLR);
    assign start_clr  = cmd_go && (rx_data == CMD_CLEAR || rx_data == CMD_READCLR);
    assign hs         = tx_valid_q && tx_ready;

    // Byte k of the snapshot lives at snap[127-8k -: 8]; {15-k,3'b111} is
    // exactly that MSB index.
    assign idx_nxt  = idx_q + 4'd1;
    assign byte_nxt = snap_q[{4'd15 - idx_nxt, 3'b111} -: 8];

`ifdef HIST_CHECKSUM_EN
    logic [7:0] csum;
    always_comb begin
        csum = 8'h00;
        for (int i = 0; i < 16; i++) csum = csum ^ snap_q[8*i +: 8];
    end
`endif

    // ---- state register ----------------------------------------------------
    always_ff @(posedge clkin or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            clr_q      <= '0;
            dropped_q  <= '0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            clr_q      <= clr_d;
            dropped_q  <= dropped_d;
        end
    end

    // ---- next-state logic --------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_read) state_d = SEND;
`ifdef HIST_CHECKSUM_EN
            SEND: if (hs && idx_q == 4'd15) state_d = CSUM;
            CSUM: if (hs) state_d = IDLE;
`else
            SEND: if (hs && idx_q == 4'd15) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    // ---- datapath next values ----------------------------------------------
    always_comb begin
        snap_d     = snap_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        dropped_d  = dropped_q;
        clr_d      = (clr_q != 3'd0) ? clr_q - 3'd1 : 3'd0;

        if (start_read) begin
            snap_d     = {histo0, histo1, histo2, histo3};
            idx_d      = 4'd0;
            tx_valid_d = 1'b1;
            tx_data_d  = histo0[31:24];
        end

        // A CLEAR during a running pulse simply restarts the 4-cycle count.
        if (start_clr) clr_d = 3'd4;

        if (rx_valid && state_q != IDLE && dropped_q != 8'hFF)
            dropped_d = dropped_q + 8'd1;

        if (state_q == SEND && hs) begin
            if (idx_q == 4'd15) begin
                idx_d = 4'd0;
`ifdef HIST_CHECKSUM_EN
                tx_data_d = csum;
`else
                tx_valid_d = 1'b0;
`endif
            end else begin
                idx_d     = idx_nxt;
                tx_data_d = byte_nxt;
            end
        end

`ifdef HIST_CHECKSUM_EN
        if (state_q == CSUM && hs) tx_valid_d = 1'b0;
`endif
    end

    // ---- outputs -----------------------------------------------------------
    always_comb begin
        busy      = (state_q != IDLE);
        resethist = (clr_q != 3'd0);
        tx_data   = tx_data_q;
        tx_valid  = tx_valid_q;
        dropped   = dropped_q;
    end

endmodule

// File: tb/tb_hist_readout.sv
// ----------------------------------------------------------------------------
// tb_hist_readout
//
// Directed scenarios followed by a randomized phase. A transaction-level
// reference model tracks the expected byte queue, the cycle at which the
// clear pulse ends, and the dropped-command count. DUT outputs are compared
// 1 time unit after every rising edge. Define HIST_CHECKSUM_EN for both
// files to exercise the checksum byte.
// ----------------------------------------------------------------------------
module tb_hist_readout;

    logic        clkin = 1'b0;
    logic        nrst;
    logic [31:0] histo0, histo1, histo2, histo3;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        resethist;
    logic        busy;
    logic [7:0]  dropped;

    hist_readout dut (
        .clkin(clkin), .nrst(nrst),
        .histo0(histo0), .histo1(histo1), .histo2(histo2), .histo3(histo3),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .resethist(resethist), .busy(busy), .dropped(dropped)
    );

    always #5 clkin = ~clkin;

    // ---- reference model state ---------------------------------------------
    logic [7:0] exp_q[$];     // bytes still to be transmitted
    int         cyc;          // index of the cycle that follows the last edge
    int         clr_end;      // last cycle in which resethist must be high
    int         exp_drop;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        clr_end  = -100;
        exp_drop = 0;
    endtask

    // Advance one clock: the model consumes the inputs of the ending cycle,
    // then every output is compared against it.
    task automatic tick();
        bit         hs, acc;
        logic [31:0] h[4];
        logic [7:0]  x;
        hs  = (exp_q.size() != 0) && tx_ready;
        acc = rx_valid && (exp_q.size() == 0);
        h[0] = histo0; h[1] = histo1; h[2] = histo2; h[3] = histo3;
        if (rx_valid && !acc && exp_drop < 255) exp_drop++;
        @(posedge clkin);
        cyc++;
        if (hs) void'(exp_q.pop_front());
        if (acc && (rx_data == 8'h01 || rx_data == 8'h03)) begin
            x = 8'h00;
            for (int c = 0; c < 4; c++)
                for (int b = 3; b >= 0; b--) begin
                    exp_q.push_back(h[c][8*b +: 8]);
                    x ^= h[c][8*b +: 8];
                end
`ifdef HIST_CHECKSUM_EN
            exp_q.push_back(x);
`endif
        end
        if (acc && (rx_data == 8'h02 || rx_data == 8'h03)) clr_end = cyc + 3;
        #1;
        chk("tx_valid", tx_valid, exp_q.size() != 0);
        chk("busy", busy, exp_q.size() != 0);
        if (exp_q.size() != 0) chk("tx_data", tx_data, exp_q[0]);
        chk("resethist", resethist, cyc <= clr_end);
        chk("dropped", dropped, exp_drop);
    endtask

    task automatic cmd(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Run until the model queue drains, with a bounded cycle budget.
    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        nrst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        histo0 = 32'h01020304; histo1 = 32'h05060708;
        histo2 = 32'h090A0B0C; histo3 = 32'h0D0E0F10;
        cyc = 0;
        model_reset();
        repeat (3) @(posedge clkin);
        #1;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_resethist", resethist, 0);
        chk("rst_dropped", dropped, 0);
        nrst = 1'b1;
        tick();

        // 1: basic READ with tx_ready high, bytes 0x01..0x10
        cmd(8'h01);
        chk("first_byte", tx_data, 8'h01);
        drain(40);
        tick();

        // 2: histo0 increments every cycle during READ
        histo0 = 32'h00FF_FFF0;
        rx_data = 8'h01; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin histo0 = histo0 + 1; tick(); end
        drain(40);

        // 3: backpressure pattern 1,0,0,1,...
        cmd(8'h01);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) begin
            tx_ready = (i % 3 == 0);
            tick();
        end
        tx_ready = 1'b1;
        drain(40);

        // 4: CLEAR, then a second CLEAR two cycles later extends the pulse
        cmd(8'h02);
        tick();
        cmd(8'h02);
        repeat (6) tick();

        // 5: READCLR, READ mid-stream dropped, unknown opcode in IDLE ignored
        cmd(8'h03);
        repeat (3) tick();
        cmd(8'h01);
        chk("drop_one", dropped, 8'd1);
        drain(40);
        cmd(8'h7F);
        tick();
        chk("unknown_ignored", dropped, 8'd1);

        // 6: reset mid-stream at byte 7, then a fresh full stream
        cmd(8'h01);
        repeat (7) tick();
        chk("byte7", tx_data, 8'h08);
        #2 nrst = 1'b0;
        #1;
        chk("async_tx_valid", tx_valid, 0);
        chk("async_busy", busy, 0);
        chk("async_dropped", dropped, 0);
        model_reset();
        @(posedge clkin);
        cyc++;
        #1 nrst = 1'b1;
        cmd(8'h01);
        chk("restart_byte0", tx_data, 8'h01);
        drain(40);

        // 7: randomized traffic
        for (int i = 0; i < 3000; i++) begin
            histo0 = $urandom; histo1 = $urandom; histo2 = $urandom; histo3 = $urandom;
            tx_ready = ($urandom_range(0, 3) != 0);
            rx_valid = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: rx_data = 8'h01;
                1: rx_data = 8'h02;
                2: rx_data = 8'h03;
                default: rx_data = 8'($urandom);
            endcase
            tick();
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        drain(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hist_readout.md
# hist_readout

Command-driven readout stage downstream of the photon-coincidence/histogram block. On a command byte from the host UART receiver it atomically snapshots the four 32-bit histogram counters, streams them as bytes to the UART transmitter over a valid/ready handshake, and optionally pulses `resethist` back to the histogram block to clear it. Everything runs in the `clkin` domain, the same clock as the histogram counters.

## Interface
- No parameters.
- `clkin`  in  1  system clock; all logic on rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `histo0`..`histo3`  in  32 each  live histogram counters.
- `rx_data`  in  8  command byte from UART receiver.
- `rx_valid`  in  1  one-cycle strobe, `rx_data` valid.
- `tx_data`  out  8  byte to UART transmitter.
- `tx_valid`  out  1  `tx_data` valid.
- `tx_ready`  in  1  transmitter accepts a byte when `tx_valid && tx_ready`.
- `resethist`  out  1  clear request to the histogram block.
- `busy`  out  1  high whenever state is not IDLE.
- `dropped`  out  8  saturating count of commands ignored because `busy` was high.

## Operation
- States: IDLE, SEND, CSUM (CSUM exists only with the macro).
- Commands, sampled only in IDLE when `rx_valid` is high:
  - 0x01 (READ): snapshot, then SEND.
  - 0x02 (CLEAR): start the clear pulse only; stay in IDLE.
  - 0x03 (READCLR): snapshot, start the clear pulse, then SEND.
  - Any other value: ignored; no state change, `dropped` unchanged.
- Snapshot: all four `histo*` are captured on the same edge into 128-bit register `snap`. The snapshot is never updated during SEND.
- SEND: 4-bit byte index `idx` runs 0..15.
  - Byte order: `histo0` first, each counter MSB byte first. Byte k = `snap[127-8k -: 8]`.
  - `idx` advances only on a handshake.
  - Handshake on `idx`=15 goes to CSUM if the macro is defined, otherwise IDLE.
- Clear pulse: a 3-bit down-counter loaded with 4. `resethist` is high while the counter is nonzero, so it is high for exactly 4 cycles. It runs independently of SEND.
  - A new CLEAR while the counter is nonzero reloads it to 4.
  - CLEAR does not make `busy` high. When `busy` is low, CLEAR is accepted during a running pulse.
- `rx_valid` while `busy` is high: the command is discarded and `dropped` increments, saturating at 255. This applies to every byte value, including unknown ones.
- Reset (any time, including mid-stream):
  - `tx_valid`=0, `tx_data`=0x00, `resethist`=0, `busy`=0, `dropped`=0.
  - `snap`=0, `idx`=0, state IDLE.
  - A partial stream is abandoned and not resumed.

## Timing
- READ/READCLR with `rx_valid` in cycle N:
  - `snap` holds the `histo*` values present in cycle N.
  - `tx_valid`=1 and `busy`=1 from cycle N+1, with the first byte on `tx_data`.
- READCLR: `resethist` is high in cycles N+1..N+4. Counts arriving before the clear takes effect (the histogram block's 2-flop resethist sync, plus 4 cycles) are lost. This is accepted behaviour.
- CLEAR: `resethist` is high in cycles N+1..N+4.
- With `tx_ready` tied high, one byte is transferred per cycle.
  - Without checksum: 16 cycles; `tx_valid` is low and `busy` is low from cycle N+17.
  - With checksum: 17 cycles; low from cycle N+18.
- `tx_data` and `tx_valid` are registered. `tx_data` is stable while `tx_valid && !tx_ready`; `tx_valid` never drops without a handshake (except on reset).
- Next command is accepted in the first cycle in which `busy` is low.

## Configuration
- `HIST_CHECKSUM_EN` defined:
  - After byte 15, a 17th byte is sent in state CSUM: XOR of the 16 data bytes, under the same handshake.
  - A handshake in CSUM returns the block to IDLE.
- Not defined: no CSUM state; the stream is exactly 16 bytes.

## Test plan
- Reset, `tx_ready`=1, `histo0..3`=0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10, `rx_data`=0x01 -> bytes 0x01..0x10 in order on cycles N+1..N+16; `resethist` stays 0. With the macro, a 17th byte 0x10 (XOR of 0x01..0x10) follows.
- `histo0` increments every cycle during READ -> streamed `histo0` equals its value in cycle N.
- Backpressure: `tx_ready` toggles 1,0,0,1,... -> no byte duplicated or skipped; `tx_data` is constant while stalled.
- 0x02 -> `resethist`=1 for exactly cycles N+1..N+4, `busy` stays 0. A second 0x02 at N+2 extends the pulse through N+6.
- 0x03 -> full 16-byte stream of pre-clear values, with `resethist` high N+1..N+4. 0x01 sent mid-stream -> ignored, `dropped`=1. 0x7F in IDLE -> no response, `dropped` unchanged.
- `nrst` low at byte 7 -> `tx_valid`, `busy`, `dropped` all 0 immediately. A new 0x01 after release -> complete stream starting from byte 0.
